pullit: RTL
===========

PULLIT -- requirements
Module: pullit

Interface
REQ-001 The parameter list SHALL be: TRIGHDR, 8'h81, header byte opening a trigger record.
REQ-002 The parameter list SHALL further include: CYCHDR, 8'h82, header byte opening a cycle record.
REQ-003 Port clk SHALL be: input, 1, the single clock; all logic is on posedge clk.
REQ-004 Port reset SHALL be: input, 1, asynchronous, active-high reset.
REQ-005 Port data SHALL be: input, 8, stream byte, sampled when write=1.
REQ-006 Port write SHALL be: input, 1, byte strobe, one byte per clk cycle while high.
REQ-007 Port busy SHALL be: output, 1, backpressure to the stream writer.
REQ-008 Port trigvalid SHALL be: output, 1, a decoded trigger record is held.
REQ-009 Port cyclevalid SHALL be: output, 1, a decoded cycle record is held.
REQ-010 Port trignum SHALL be: output, 18, decoded trigger number.
REQ-011 Port cyclenum SHALL be: output, 18, decoded cycle number.
REQ-012 Port timenum SHALL be: output, 36, decoded trigger time.
REQ-013 Port ack SHALL be: input, 1, consumer releases the held record.
REQ-014 Port errcnt SHALL be: output, 8, saturating count of framing errors.

Function
REQ-015 The stream format SHALL be:
- Header byte: bit7=1.
- Payload bytes: bit7=0, 7 data bits in [6:0], MSB-first.
REQ-016 A trigger record SHALL be 10 bytes:
- TRIGHDR.
- 3 bytes of trignum: byte1[3:0]=[17:14], [6:4] must be 0; then [13:7]; then [6:0].
- 6 bytes of timenum: byte4[0]=[35], [6:1] must be 0; then five 7-bit groups [34:28] down to [6:0].
REQ-017 A cycle record SHALL be 4 bytes: CYCHDR, then 3 bytes of cyclenum in the trignum layout.
REQ-018 The FSM SHALL have the states IDLE, TRIG, CYC and HOLD, with a 4-bit byte index inside TRIG/CYC.
REQ-019 In IDLE:
- A write of TRIGHDR SHALL go to TRIG.
- A write of CYCHDR SHALL go to CYC.
- Any other header SHALL increment errcnt and stay IDLE.
- A payload byte SHALL increment errcnt and be discarded.
REQ-020 In TRIG/CYC each payload byte SHALL shift into a shadow register; output registers SHALL NOT change before record completion.
REQ-021 A header byte arriving in TRIG/CYC SHALL abort the record and increment errcnt, then be processed exactly as in IDLE in the same cycle (resync).
REQ-022 Non-zero must-be-0 pad bits SHALL cause the record to be discarded, errcnt to increment once, and the FSM to return to IDLE after the last byte.
REQ-023 On the last valid byte, the FSM SHALL enter HOLD and, on the next clk edge, load trignum+timenum (trigvalid=1) or cyclenum (cyclevalid=1). Latency is 1 cycle after the final write cycle.
REQ-024 Only the decoded fields SHALL update; the other field outputs retain their previous values.
REQ-025 busy SHALL equal trigvalid|cyclevalid (registered).
REQ-026 ack=1 in HOLD SHALL clear trigvalid/cyclevalid and busy on the next edge and return to IDLE; ack outside HOLD SHALL be ignored.
REQ-027 A write while busy=1 SHALL be dropped and increment errcnt (overrun); the held record is unaffected.
REQ-028 ack and write in the same HOLD cycle SHALL release the record, drop the byte, and count it as an overrun.
REQ-029 errcnt SHALL saturate at 8'hFF; multiple error causes in one cycle count once.

Reset
REQ-030 reset=1 SHALL immediately force IDLE and clear the shadow registers and byte index.
REQ-031 reset=1 SHALL immediately force busy=0, trigvalid=0, cyclevalid=0, trignum=0, cyclenum=0, timenum=0 and errcnt=0.
REQ-032 Reset mid-record or in HOLD SHALL discard all partial or held data; the first record after release is decoded normally.

Verification
REQ-033 Trigger decode: 81,04,46,45,00,12,1A,15,4F,09 on consecutive cycles -> trigvalid=1, trignum=18'h12345, timenum=36'h123456789 one cycle after the last byte; busy=1 until ack.
REQ-034 Cycle decode: 82,09,4F,09 -> cyclevalid=1, cyclenum=18'h26789; trignum/timenum unchanged.
REQ-035 Resync: 81,04,46 then 82,09,4F,09 -> errcnt=1, cyclevalid=1, cyclenum=18'h26789, trigvalid=0.
REQ-036 Overrun: a byte written while busy=1 -> errcnt+1, held outputs unchanged.
REQ-037 Pad and sparse writes: 82,19,4F,09 -> record discarded, errcnt+1, no valid. A trigger record with write gaps between bytes -> same result as contiguous writes.
REQ-038 Reset and saturation: reset mid-record -> all outputs 0. 300 stray payload bytes -> errcnt=8'hFF.

Source files
------------

// File: rtl/pullit.sv
// Stream record decoder: frames trigger and cycle records from a
// header/payload byte stream and holds the decoded fields until acked.
module pullit #(
    parameter logic [7:0] TRIGHDR = 8'h81,
    parameter logic [7:0] CYCHDR  = 8'h82
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data,
    input  logic        write,
    output logic        busy,
    output logic        trigvalid,
    output logic        cyclevalid,
    output logic [17:0] trignum,
    output logic [17:0] cyclenum,
    output logic [35:0] timenum,
    input  logic        ack,
    output logic [7:0]  errcnt
);

    typedef enum logic [1:0] {IDLE, TRIG, CYC, HOLD} state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [20:0] sh_num;
    logic [41:0] sh_time;
    logic        hold_trig;

    logic        is_hdr;
    logic        hdr_ok;
    logic        last;
    logic        pad;
    logic        err;
    logic [20:0] num_nx;
    logic [41:0] time_nx;

    // Shadows keep the pad bits so the must-be-zero check runs on the last byte
    always_comb begin
        is_hdr  = data[7];
        hdr_ok  = (data == TRIGHDR) || (data == CYCHDR);
        num_nx  = {sh_num[13:0], data[6:0]};
        time_nx = {sh_time[34:0], data[6:0]};
        last    = ((state == TRIG) && (idx == 4'd8)) ||
                  ((state == CYC) && (idx == 4'd2));
        if (state == TRIG)
            pad = (sh_num[20:18] != 3'd0) || (time_nx[41:36] != 6'd0);
        else
            pad = (num_nx[20:18] != 3'd0);
        err = 1'b0;
        if (write) begin
            case (state)
                IDLE:     err = !hdr_ok;
                TRIG,
                CYC:      err = is_hdr || (last && pad);
                default:  err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 4'd0;
            sh_num     <= '0;
            sh_time    <= '0;
            hold_trig  <= 1'b0;
            busy       <= 1'b0;
            trigvalid  <= 1'b0;
            cyclevalid <= 1'b0;
            trignum    <= '0;
            cyclenum   <= '0;
            timenum    <= '0;
            errcnt     <= '0;
        end else begin
            if (err && (errcnt != 8'hFF))
                errcnt <= errcnt + 8'd1;
            case (state)
                IDLE, TRIG, CYC: begin
                    if (write) begin
                        if (is_hdr) begin
                            idx     <= 4'd0;
                            sh_num  <= '0;
                            sh_time <= '0;
                            if (data == TRIGHDR)
                                state <= TRIG;
                            else if (data == CYCHDR)
                                state <= CYC;
                            else
                                state <= IDLE;
                        end else if (state != IDLE) begin
                            idx <= idx + 4'd1;
                            if ((state == CYC) || (idx < 4'd3))
                                sh_num <= num_nx;
                            else
                                sh_time <= time_nx;
                            if (last) begin
                                state     <= pad ? IDLE : HOLD;
                                hold_trig <= (state == TRIG);
                            end
                        end
                    end
                end
                default: begin
                    if (!busy) begin
                        busy <= 1'b1;
                        if (hold_trig) begin
                            trigvalid <= 1'b1;
                            trignum   <= sh_num[17:0];
                            timenum   <= sh_time[35:0];
                        end else begin
                            cyclevalid <= 1'b1;
                            cyclenum   <= sh_num[17:0];
                        end
                    end else if (ack) begin
                        busy       <= 1'b0;
                        trigvalid  <= 1'b0;
                        cyclevalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
